// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq
//   ALU control decoder with an optional sequential shift-add multiplier.
//
//   Build option: define ALU_CTRL_SEQ_MUL_EN to compile in the multi-cycle
//   multiply FSM. In the default build, mul decodes to a single-cycle ALU
//   operation and the multiplier outputs are tied to zero.
//
//   Parameters
//     XLEN    operand/result width (8..64)
//     CTRL_W  ALU control code width (>= 4)
//
//   Ports
//     clk_i         sole clock, rising edge
//     rst_i         synchronous, active-low reset
//     valid_i       EX-stage instruction valid
//     flush_i       flush of the EX instruction
//     ALUOp_i       main-decoder op class
//     funct_i       {funct7, funct3}
//     rs1_i/rs2_i   multiply operands
//     ALUCtrl_o     ALU operation code (combinational)
//     illegal_o     unsupported ALUOp/funct combination (combinational)
//     stall_o       hold IF/ID/EX while the multiply runs
//     mul_done_o    one-cycle multiply completion pulse
//     mul_result_o  low XLEN bits of the last completed product
module alu_ctrl_seq #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [9:0]        funct_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              illegal_o,
    output logic              stall_o,
    output logic              mul_done_o,
    output logic [XLEN-1:0]   mul_result_o
);

    logic [3:0] ctrl_code;
    logic       is_mul;

    // Decoder is purely combinational and independent of reset.
    always_comb begin
        ctrl_code = 4'b0010;
        illegal_o = 1'b0;
        is_mul    = 1'b0;
        case (ALUOp_i)
            2'b00: ctrl_code = 4'b0010;
            2'b01: ctrl_code = 4'b0110;
            2'b10: begin
                case (funct_i)
                    10'b0000000111: ctrl_code = 4'b0000;
                    10'b0000000110: ctrl_code = 4'b0001;
                    10'b0000000000: ctrl_code = 4'b0010;
                    10'b0100000000: ctrl_code = 4'b0110;
                    10'b0000001000: begin
                        ctrl_code = 4'b0011;
                        is_mul    = 1'b1;
                    end
                    10'b0000000100: ctrl_code = 4'b0100;
                    10'b0000000001: ctrl_code = 4'b0101;
                    10'b0100000101: ctrl_code = 4'b0111;
                    default: begin
                        ctrl_code = 4'b0010;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl_code = 4'b0010;
                illegal_o = 1'b1;
            end
        endcase
    end

    assign ALUCtrl_o = CTRL_W'(ctrl_code);

`ifdef ALU_CTRL_SEQ_MUL_EN

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   acc_sum;
    logic [XLEN-1:0]   result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              start;
    logic              last_bit;

    // Start is gated by reset so stall_o stays low while reset is held.
    assign start    = rst_i && (state_q == IDLE) && valid_i && is_mul && !flush_i;
    assign last_bit = (cnt_q == CNT_W'(XLEN - 1));
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stall_o    = 1'b0;
        mul_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = start;
                if (start) state_d = RUN;
            end
            RUN: begin
                stall_o = 1'b1;
                if (flush_i)       state_d = IDLE;
                else if (last_bit) state_d = DONE;
            end
            DONE: begin
                mul_done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift-add datapath: multiplicand shifts left, multiplier shifts right,
    // one multiplier bit consumed per RUN cycle. The product is captured on
    // the final bit so it is already valid during DONE.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= rs1_i;
                        mplier_q <= rs2_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
                    if (!flush_i) begin
                        acc_q    <= acc_sum;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (last_bit) result_q <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_result_o = result_q;

`else

    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_i, valid_i, flush_i, is_mul, rs1_i, rs2_i};

    assign stall_o      = 1'b0;
    assign mul_done_o   = 1'b0;
    assign mul_result_o = '0;

`endif

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand/result width; legal range 8..64.
REQ-002 The block SHALL have parameter CTRL_W, default 4, ALU control code width; minimum 4.
REQ-003 The block SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset; synchronous and active-low.
REQ-005 The block SHALL have port valid_i  input  1  EX-stage instruction valid.
REQ-006 The block SHALL have port flush_i  input  1  pipeline flush of the EX instruction.
REQ-007 The block SHALL have port ALUOp_i  input  2  main-decoder op class.
REQ-008 The block SHALL have port funct_i  input  10  {funct7, funct3}.
REQ-009 The block SHALL have ports rs1_i and rs2_i  input  XLEN each  multiply operands.
REQ-010 The block SHALL have port ALUCtrl_o  output  CTRL_W  ALU operation code.
REQ-011 The block SHALL have port illegal_o  output  1  unsupported ALUOp/funct combination.
REQ-012 The block SHALL have port stall_o  output  1  hold IF/ID/EX while the multiply runs.
REQ-013 The block SHALL have ports mul_done_o  output  1 and mul_result_o  output  XLEN  multiply completion pulse and low XLEN product bits.

Function
REQ-014 ALUCtrl_o SHALL be combinational, zero-extended to CTRL_W: ALUOp 00 -> 0010 (add); 01 -> 0110 (sub, branch).
REQ-015 For ALUOp 10, funct 0000000111 -> 0000 and; 0000000110 -> 0001 or; 0000000000 -> 0010 add; 0100000000 -> 0110 sub; 0000001000 -> 0011 mul; 0000000100 -> 0100 xor; 0000000001 -> 0101 sll; 0100000101 -> 0111 sra.
REQ-016 Unlisted funct under ALUOp 10, or ALUOp 11, SHALL drive ALUCtrl_o = 0010 and illegal_o = 1; otherwise illegal_o = 0; no output latching.
REQ-017 The multiply FSM SHALL have states IDLE, RUN, DONE.
REQ-018 IDLE -> RUN when valid_i=1, decoded op is mul, flush_i=0; rs1_i/rs2_i latched, accumulator and bit counter cleared.
REQ-019 RUN SHALL process one multiplier bit per cycle (shift-add, product mod 2^XLEN); after exactly XLEN RUN cycles -> DONE.
REQ-020 DONE SHALL last one cycle with mul_done_o = 1 and mul_result_o valid, then -> IDLE; valid_i is ignored in DONE.
REQ-021 mul_result_o SHALL hold the last product until the next multiply completes or reset.
REQ-022 stall_o SHALL equal (IDLE and start condition of REQ-018) or RUN; 0 in DONE.
REQ-023 Latency: issue at cycle T, mul_done_o at T+XLEN+1; stall_o high T..T+XLEN.
REQ-024 flush_i in RUN SHALL force IDLE next cycle with no mul_done_o; flush_i with issue in IDLE SHALL prevent the start; flush_i in DONE has no effect.
REQ-025 Operand changes on rs1_i/rs2_i during RUN SHALL not affect the result.

Reset
REQ-026 With rst_i = 0 at a rising edge: state IDLE, counter 0, accumulator 0, mul_result_o 0, mul_done_o 0, stall_o 0 from the next cycle.
REQ-027 Reset mid-RUN SHALL abandon the multiply with no mul_done_o pulse.
REQ-028 ALUCtrl_o/illegal_o SHALL follow inputs even during reset.

Configuration
REQ-029 Macro ALU_CTRL_SEQ_MUL_EN defined: multiply FSM of REQ-017..REQ-027 compiled in.
REQ-030 Macro undefined: FSM removed; mul decodes to 0011 for single-cycle ALU multiply; stall_o, mul_done_o, mul_result_o tied to 0.

Verification
REQ-031 XLEN=32, ALUOp 10, funct 0100000000 -> ALUCtrl_o 0110, illegal_o 0, stall_o 0; funct 0000000010 -> 0010, illegal_o 1.
REQ-032 mul rs1=7 rs2=6 issued at cycle 0 -> stall_o 1 cycles 0..32, mul_done_o 1 at cycle 33, mul_result_o 42.
REQ-033 mul 0xFFFFFFFF x 0x00000002, rs1 changed to 0 at cycle 5 -> mul_result_o 0xFFFFFFFE at cycle 33.
REQ-034 mul issued, flush_i at cycle 10 -> IDLE at cycle 11, stall_o 0, no mul_done_o; next mul 3x5 -> 15.
REQ-035 rst_i = 0 at cycle 12 of a multiply -> all outputs per REQ-026, no done pulse; macro undefined -> mul gives ALUCtrl_o 0011, stall_o 0.
